// File: rtl/cache_arb_pkg.sv
// ============================================================================
//  Module      : cache_arb_pkg
//  Description : Shared types and widths for the icache/dcache memory arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_arb_pkg;

    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

endpackage

`default_nettype wire

// File: rtl/cache_arbiter.sv
// ============================================================================
//  Module      : cache_arbiter
//  Description : Round-robin arbiter sharing one physical-memory line port
//                between the instruction cache and the data cache. Grants one
//                requester at a time, forwards its request downstream and
//                routes the response back to the granted cache only.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cache_arbiter #(
    parameter int ADDR_W = cache_arb_pkg::ADDR_W,
    parameter int LINE_W = cache_arb_pkg::LINE_W
) (
    input  logic              clk,
    input  logic              rst_n,
    // icache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // dcache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // physical memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    import cache_arb_pkg::*;

    arb_state_t r_state;
    req_id_t    r_last_grant;

    logic w_i_req;
    logic w_d_req;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;

    // Grant FSM: pick a requester from IDLE (round-robin on ties), hold the
    // grant until the downstream response, then drop back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= REQ_D;   // first tie after reset favours the icache
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_i_req && (!w_d_req || (r_last_grant == REQ_D))) begin
                        r_state      <= SERVE_I;
                        r_last_grant <= REQ_I;
                    end else if (w_d_req) begin
                        r_state      <= SERVE_D;
                        r_last_grant <= REQ_D;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) r_state <= IDLE;
                end
                SERVE_D: begin
                    if (pmem_resp) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Output steering: only the granted cache sees the downstream port; the
    // other side gets zero response and zero data.
    always_comb begin
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        i_rdata    = '0;
        d_resp     = 1'b0;
        d_rdata    = '0;
        case (r_state)
            SERVE_I: begin
                pmem_read = 1'b1;
                pmem_addr = i_addr;
                i_resp    = pmem_resp;
                i_rdata   = pmem_rdata;
            end
            SERVE_D: begin
                // A simultaneous read+write is illegal; the write wins.
                pmem_read  = d_read & ~d_write;
                pmem_write = d_write;
                pmem_addr  = d_addr;
                pmem_wdata = d_wdata;
                d_resp     = pmem_resp;
                d_rdata    = pmem_rdata;
            end
            default: ;
        endcase
    end

    // The dcache must never raise read and write together.
    a_no_dcache_rw: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(d_read && d_write));

endmodule

`default_nettype wire

// File: tb/tb_cache_arbiter.sv
// ============================================================================
//  Module      : tb_cache_arbiter
//  Description : Self-checking bench for cache_arbiter. Cycle vectors give the
//                request/response inputs and the grant expected in that cycle;
//                expected outputs are queued when inputs are driven and
//                compared just before the next rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cache_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    localparam logic [1:0] G_N = 2'd0;   // nothing granted
    localparam logic [1:0] G_I = 2'd1;   // icache granted
    localparam logic [1:0] G_D = 2'd2;   // dcache granted

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_read;
    logic [AW-1:0] i_addr;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_addr;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_addr;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    cache_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_read     (i_read),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_resp     (i_resp),
        .d_read     (d_read),
        .d_write    (d_write),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_resp     (d_resp),
        .pmem_read  (pmem_read),
        .pmem_write (pmem_write),
        .pmem_addr  (pmem_addr),
        .pmem_wdata (pmem_wdata),
        .pmem_rdata (pmem_rdata),
        .pmem_resp  (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       ir;
        logic       dr;
        logic       dw;
        logic       pr;
        logic [1:0] g;
    } vec_t;

    typedef struct {
        logic          prd;
        logic          pwr;
        logic [AW-1:0] pa;
        logic [LW-1:0] pwd;
        logic          ir;
        logic [LW-1:0] ird;
        logic          dr;
        logic [LW-1:0] drd;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    logic [LW-1:0] pat_a5   = {32{8'hA5}};
    logic [LW-1:0] pat_dead = {8{32'hDEAD_BEEF}};

    function automatic vec_t v(input logic r, input logic ir, input logic dr,
                               input logic dw, input logic pr, input logic [1:0] g);
        vec_t t;
        t.rst_n = r; t.ir = ir; t.dr = dr; t.dw = dw; t.pr = pr; t.g = g;
        return t;
    endfunction

    task automatic check(input int idx);
        exp_t e;
        e = sb.pop_front();
        n_vec++;
        if (pmem_read !== e.prd || pmem_write !== e.pwr || pmem_addr !== e.pa ||
            pmem_wdata !== e.pwd || i_resp !== e.ir || i_rdata !== e.ird ||
            d_resp !== e.dr || d_rdata !== e.drd) begin
            n_err++;
            $display("FAIL vec%0d: got rd=%b wr=%b addr=%h ir=%b dr=%b wd_lo=%h ird_lo=%h drd_lo=%h | want rd=%b wr=%b addr=%h ir=%b dr=%b wd_lo=%h ird_lo=%h drd_lo=%h",
                     idx, pmem_read, pmem_write, pmem_addr, i_resp, d_resp,
                     pmem_wdata[31:0], i_rdata[31:0], d_rdata[31:0],
                     e.prd, e.pwr, e.pa, e.ir, e.dr, e.pwd[31:0], e.ird[31:0], e.drd[31:0]);
        end
    endtask

    task automatic apply(input int idx, input vec_t t);
        exp_t e;
        @(negedge clk);
        rst_n      = t.rst_n;
        i_read     = t.ir;
        d_read     = t.dr;
        d_write    = t.dw;
        pmem_resp  = t.pr;
        i_addr     = 32'h0000_1000;
        d_addr     = 32'h0000_2000 | ($urandom & 32'h0000_0FF0);
        d_wdata    = pat_dead ^ {224'd0, 32'($urandom)};
        pmem_rdata = pat_a5 ^ {224'd0, 32'($urandom)};
        e.prd = 1'b0; e.pwr = 1'b0; e.pa = '0; e.pwd = '0;
        e.ir  = 1'b0; e.ird = '0;   e.dr = 1'b0; e.drd = '0;
        if (t.g == G_I) begin
            e.prd = 1'b1;
            e.pa  = i_addr;
            e.ir  = t.pr;
            e.ird = pmem_rdata;
        end else if (t.g == G_D) begin
            e.prd = t.dr & ~t.dw;
            e.pwr = t.dw;
            e.pa  = d_addr;
            e.pwd = d_wdata;
            e.dr  = t.pr;
            e.drd = pmem_rdata;
        end
        sb.push_back(e);
        #4;
        check(idx);
    endtask

    initial begin
        rst_n = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;

        // reset state
        tbl.push_back(v(0,0,0,0,0,G_N));
        tbl.push_back(v(0,0,0,0,0,G_N));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // icache-only read, response after 5 cycles
        tbl.push_back(v(1,1,0,0,0,G_N));
        for (int k = 0; k < 4; k++) tbl.push_back(v(1,1,0,0,0,G_I));
        tbl.push_back(v(1,1,0,0,1,G_I));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // dcache write-back
        tbl.push_back(v(1,0,0,1,0,G_N));
        tbl.push_back(v(1,0,0,1,0,G_D));
        tbl.push_back(v(1,0,0,1,0,G_D));
        tbl.push_back(v(1,0,0,1,1,G_D));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // simultaneous requests right after reset: icache first
        tbl.push_back(v(0,0,0,0,0,G_N));
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,0,G_I));
        tbl.push_back(v(1,1,1,0,1,G_I));
        tbl.push_back(v(1,0,1,0,0,G_N));
        tbl.push_back(v(1,0,1,0,0,G_D));
        tbl.push_back(v(1,0,1,0,1,G_D));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // continuous contention: I, D, I, D with an idle cycle between
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,0,G_I));
        tbl.push_back(v(1,1,1,0,1,G_I));
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,0,G_D));
        tbl.push_back(v(1,1,1,0,1,G_D));
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,1,G_I));
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,1,G_D));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // write-back, icache wins before the refill
        tbl.push_back(v(1,0,0,1,0,G_N));
        tbl.push_back(v(1,1,0,1,0,G_D));
        tbl.push_back(v(1,1,0,1,1,G_D));
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,1,G_I));
        tbl.push_back(v(1,0,1,0,0,G_N));
        tbl.push_back(v(1,0,1,0,1,G_D));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // reset two cycles into a write-back; late resp ignored
        tbl.push_back(v(1,0,0,1,0,G_N));
        tbl.push_back(v(1,0,0,1,0,G_D));
        tbl.push_back(v(1,0,0,1,0,G_D));
        tbl.push_back(v(0,0,0,1,0,G_N));
        tbl.push_back(v(0,0,0,1,1,G_N));
        tbl.push_back(v(1,0,0,0,0,G_N));
        // after release the first tie goes to the icache again
        tbl.push_back(v(1,1,1,0,0,G_N));
        tbl.push_back(v(1,1,1,0,1,G_I));
        tbl.push_back(v(1,0,0,0,0,G_N));

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // dcache refill with variable downstream latency, bounded wait
        begin
            int            seen;
            logic          done;
            logic [LW-1:0] got;
            logic [LW-1:0] want;
            logic          stray;
            seen = 0; done = 1'b0; got = '0; stray = 1'b0;
            want = pat_a5 ^ {224'd0, 32'h1234_5678};
            @(negedge clk);
            rst_n = 1'b1; i_read = 1'b0; d_write = 1'b0; d_read = 1'b1;
            d_addr = 32'h0000_3000; pmem_resp = 1'b0; pmem_rdata = want;
            for (int c = 0; c < 20 && !done; c++) begin
                @(negedge clk);
                pmem_resp = (seen >= 3);
                #4;
                if (pmem_read && pmem_addr !== 32'h0000_3000) stray = 1'b1;
                if (i_resp) stray = 1'b1;
                if (pmem_read) seen++;
                if (d_resp) begin
                    done = 1'b1;
                    got  = d_rdata;
                end
            end
            n_vec++;
            if (!done || got !== want || stray) begin
                n_err++;
                $display("FAIL refill_seq: got done=%b stray=%b rdata_lo=%h, want done=1 stray=0 rdata_lo=%h",
                         done, stray, got[31:0], want[31:0]);
            end
            @(negedge clk);
            d_read = 1'b0; pmem_resp = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
